// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe board controller.
//   CELL_W / P1_CODE / P2_CODE : per-cell encoding of the convert vector (Q2.5)
//   CURSOR_HOME                : cursor index after reset/restart (centre cell)
//   WIN_LINES                  : the eight winning lines as 9-bit cell masks
//   cursor_* functions         : non-wrapping cursor moves on the 3x3 grid
package ttt_pkg;

  localparam int                        CELL_W      = 7;
  localparam logic signed [CELL_W-1:0]  P1_CODE     = 7'sh20;  // +1.0
  localparam logic signed [CELL_W-1:0]  P2_CODE     = 7'sh60;  // -1.0
  localparam logic [3:0]                CURSOR_HOME = 4'd4;

  localparam int N_CELLS = 9;
  localparam int N_LINES = 8;

  // Bit positions inside the sampled button vector {C,U,D,L,R}
  localparam int BTN_R = 0;
  localparam int BTN_L = 1;
  localparam int BTN_D = 2;
  localparam int BTN_U = 3;
  localparam int BTN_C = 4;

  localparam logic [N_LINES-1:0][N_CELLS-1:0] WIN_LINES = {
    9'h007,  // row    {0,1,2}
    9'h038,  // row    {3,4,5}
    9'h1C0,  // row    {6,7,8}
    9'h049,  // column {0,3,6}
    9'h092,  // column {1,4,7}
    9'h124,  // column {2,5,8}
    9'h111,  // diag   {0,4,8}
    9'h054   // diag   {2,4,6}
  };

  typedef enum logic {
    TURN_P1 = 1'b0,
    TURN_P2 = 1'b1
  } turn_e;

  function automatic logic [3:0] cursor_up(input logic [3:0] idx);
    return (idx >= 4'd3) ? idx - 4'd3 : idx;
  endfunction

  function automatic logic [3:0] cursor_down(input logic [3:0] idx);
    return (idx <= 4'd5) ? idx + 4'd3 : idx;
  endfunction

  // Left edge is column 0: cells 0, 3, 6
  function automatic logic [3:0] cursor_left(input logic [3:0] idx);
    return (idx == 4'd0 || idx == 4'd3 || idx == 4'd6) ? idx : idx - 4'd1;
  endfunction

  // Right edge is column 2: cells 2, 5, 8
  function automatic logic [3:0] cursor_right(input logic [3:0] idx);
    return (idx == 4'd2 || idx == 4'd5 || idx == 4'd8) ? idx : idx + 4'd1;
  endfunction

endpackage

// File: rtl/ttt_board_ctrl_if.sv
// Button / board bundle between the push-button front-end (master) and the
// board controller (slave).
//   restart, BtnU/D/L/R/C : requests into the controller
//   I, P1, P2, board, P1Won, P2Won, PlayerMoved, convert : board state out
interface ttt_board_ctrl_if;
  import ttt_pkg::*;

  logic                      restart;
  logic                      BtnU;
  logic                      BtnD;
  logic                      BtnL;
  logic                      BtnR;
  logic                      BtnC;
  logic [3:0]                I;
  logic [N_CELLS-1:0]        P1;
  logic [N_CELLS-1:0]        P2;
  logic [N_CELLS-1:0]        board;
  logic                      P1Won;
  logic                      P2Won;
  logic                      PlayerMoved;
  logic [N_CELLS*CELL_W-1:0] convert;

  modport master (
    output restart, BtnU, BtnD, BtnL, BtnR, BtnC,
    input  I, P1, P2, board, P1Won, P2Won, PlayerMoved, convert
  );

  modport slave (
    input  restart, BtnU, BtnD, BtnL, BtnR, BtnC,
    output I, P1, P2, board, P1Won, P2Won, PlayerMoved, convert
  );

endinterface

// File: rtl/ttt_win_detect.sv
// Combinational three-in-a-line detector for one player's occupancy mask.
//   mask     : 9-bit occupancy, bit i = cell i
//   has_line : high when any of the eight win lines is fully occupied
module ttt_win_detect
  import ttt_pkg::*;
(
  input  logic [N_CELLS-1:0] mask,
  output logic               has_line
);

  logic [N_LINES-1:0] line_hit;

  for (genvar gi = 0; gi < N_LINES; gi++) begin : g_line
    assign line_hit[gi] = ((mask & WIN_LINES[gi]) == WIN_LINES[gi]);
  end

  assign has_line = |line_hit;

endmodule

// File: rtl/ttt_board_ctrl.sv
// Tic-tac-toe board controller.
//   Clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : slave side of ttt_board_ctrl_if (buttons/restart in, board out)
// Buttons act on a sampled 0->1 transition only, one action per cycle with
// priority C > U > D > L > R. Win flags are registered from the post-move
// masks so they appear together with the PlayerMoved pulse.
module ttt_board_ctrl
  import ttt_pkg::*;
(
  input  logic        Clk,
  input  logic        reset,
  ttt_board_ctrl_if.slave bus
);

  logic [3:0]         cursor_reg, cursor_next;
  logic [N_CELLS-1:0] p1_reg, p1_next;
  logic [N_CELLS-1:0] p2_reg, p2_next;
  turn_e              turn_reg, turn_next;
  logic               moved_reg, moved_next;
  logic               p1_won_reg, p2_won_reg;
  logic               p1_line, p2_line;
  logic [4:0]         btn_hist_reg, btn_now, btn_rise;
  logic [N_CELLS-1:0] board;
  logic               game_over;

  assign btn_now   = {bus.BtnC, bus.BtnU, bus.BtnD, bus.BtnL, bus.BtnR};
  assign btn_rise  = btn_now & ~btn_hist_reg;
  assign board     = p1_reg | p2_reg;
  assign game_over = p1_won_reg | p2_won_reg;

  always_comb begin
    cursor_next = cursor_reg;
    p1_next     = p1_reg;
    p2_next     = p2_reg;
    turn_next   = turn_reg;
    moved_next  = 1'b0;
    if (bus.restart) begin
      cursor_next = CURSOR_HOME;
      p1_next     = '0;
      p2_next     = '0;
      turn_next   = TURN_P1;
    end else if (btn_rise[BTN_C]) begin
      // A rejected placement still consumes the cycle: lower buttons do not act.
      if (!board[cursor_reg] && !game_over) begin
        if (turn_reg == TURN_P1) begin
          p1_next[cursor_reg] = 1'b1;
          turn_next           = TURN_P2;
        end else begin
          p2_next[cursor_reg] = 1'b1;
          turn_next           = TURN_P1;
        end
        moved_next = 1'b1;
      end
    end else if (btn_rise[BTN_U]) begin
      cursor_next = cursor_up(cursor_reg);
    end else if (btn_rise[BTN_D]) begin
      cursor_next = cursor_down(cursor_reg);
    end else if (btn_rise[BTN_L]) begin
      cursor_next = cursor_left(cursor_reg);
    end else if (btn_rise[BTN_R]) begin
      cursor_next = cursor_right(cursor_reg);
    end
  end

  ttt_win_detect u_p1_win (.mask(p1_next), .has_line(p1_line));
  ttt_win_detect u_p2_win (.mask(p2_next), .has_line(p2_line));

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      cursor_reg   <= CURSOR_HOME;
      p1_reg       <= '0;
      p2_reg       <= '0;
      turn_reg     <= TURN_P1;
      moved_reg    <= 1'b0;
      p1_won_reg   <= 1'b0;
      p2_won_reg   <= 1'b0;
      btn_hist_reg <= '0;
    end else begin
      cursor_reg   <= cursor_next;
      p1_reg       <= p1_next;
      p2_reg       <= p2_next;
      turn_reg     <= turn_next;
      moved_reg    <= moved_next;
      // Masks only grow between restarts, so a detected line stays detected.
      p1_won_reg   <= p1_line;
      p2_won_reg   <= p2_line;
      btn_hist_reg <= bus.restart ? 5'd0 : btn_now;
    end
  end

  assign bus.I           = cursor_reg;
  assign bus.P1          = p1_reg;
  assign bus.P2          = p2_reg;
  assign bus.board       = board;
  assign bus.P1Won       = p1_won_reg;
  assign bus.P2Won       = p2_won_reg;
  assign bus.PlayerMoved = moved_reg;

  for (genvar gi = 0; gi < N_CELLS; gi++) begin : g_convert
    assign bus.convert[gi*CELL_W +: CELL_W] =
      p1_reg[gi] ? P1_CODE : (p2_reg[gi] ? P2_CODE : '0);
  end

endmodule

// File: tb/tb_ttt_board_ctrl.sv
// Self-checking bench for ttt_board_ctrl: directed sequences followed by
// random button traffic, compared against a cell-array game model.
module tb_ttt_board_ctrl;

  logic Clk = 1'b0;
  logic reset;

  ttt_board_ctrl_if intf();

  ttt_board_ctrl dut (
    .Clk  (Clk),
    .reset(reset),
    .bus  (intf.slave)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  // Game model: cells hold 0 (empty), 1 (player 1) or 2 (player 2)
  int m_cells[9];
  int m_cursor;
  int m_turn;
  int m_winner;

  typedef struct {
    logic [8:0]  p1;
    logic [8:0]  p2;
    logic [3:0]  cur;
    logic        w1;
    logic        w2;
    logic [62:0] conv;
  } exp_t;

  exp_t exp_q[$];

  function automatic logic [8:0] model_mask(input int who);
    logic [8:0] m;
    m = '0;
    for (int i = 0; i < 9; i++) if (m_cells[i] == who) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [62:0] model_conv();
    logic [62:0] v;
    v = '0;
    for (int i = 0; i < 9; i++) begin
      if (m_cells[i] == 1)      v[7*i +: 7] = 7'h20;
      else if (m_cells[i] == 2) v[7*i +: 7] = 7'h60;
    end
    return v;
  endfunction

  function automatic bit same3(input int a, input int b, input int c, input int who);
    return (m_cells[a] == who) && (m_cells[b] == who) && (m_cells[c] == who);
  endfunction

  function automatic bit has_won(input int who);
    bit w;
    w = 0;
    for (int k = 0; k < 3; k++) begin
      if (same3(3*k, 3*k+1, 3*k+2, who)) w = 1;
      if (same3(k, k+3, k+6, who))       w = 1;
    end
    if (same3(0, 4, 8, who)) w = 1;
    if (same3(2, 4, 6, who)) w = 1;
    return w;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 9; i++) m_cells[i] = 0;
    m_cursor = 4;
    m_turn   = 1;
    m_winner = 0;
    exp_q.delete();
  endfunction

  // mask bits: {C,U,D,L,R}; only the highest-priority pressed button acts
  function automatic void model_apply(input logic [4:0] m);
    exp_t e;
    int row, col;
    row = m_cursor / 3;
    col = m_cursor % 3;
    if (m[4]) begin
      if (m_cells[m_cursor] == 0 && m_winner == 0) begin
        m_cells[m_cursor] = m_turn;
        if (has_won(m_turn)) m_winner = m_turn;
        m_turn = 3 - m_turn;
        e.p1   = model_mask(1);
        e.p2   = model_mask(2);
        e.cur  = 4'(m_cursor);
        e.w1   = (m_winner == 1);
        e.w2   = (m_winner == 2);
        e.conv = model_conv();
        exp_q.push_back(e);
      end
    end else if (m[3]) begin
      if (row > 0) row--;
    end else if (m[2]) begin
      if (row < 2) row++;
    end else if (m[1]) begin
      if (col > 0) col--;
    end else if (m[0]) begin
      if (col < 2) col++;
    end
    m_cursor = 3*row + col;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_I"},       64'(intf.I),           64'(m_cursor));
    check({tag, "_P1"},      64'(intf.P1),          64'(model_mask(1)));
    check({tag, "_P2"},      64'(intf.P2),          64'(model_mask(2)));
    check({tag, "_board"},   64'(intf.board),       64'(model_mask(1) | model_mask(2)));
    check({tag, "_P1Won"},   64'(intf.P1Won),       64'(m_winner == 1));
    check({tag, "_P2Won"},   64'(intf.P2Won),       64'(m_winner == 2));
    check({tag, "_convert"}, 64'(intf.convert),     64'(model_conv()));
    check({tag, "_moved0"},  64'(intf.PlayerMoved), 64'd0);
    check({tag, "_pending"}, 64'(exp_q.size()),     64'd0);
    $display("[TB] %s: I=%0d P1=%h P2=%h won=%b%b", tag, intf.I, intf.P1, intf.P2,
             intf.P1Won, intf.P2Won);
  endtask

  // Scoreboard monitor: every PlayerMoved pulse must match a queued placement
  always @(negedge Clk) begin
    exp_t e;
    if (reset === 1'b0 && intf.PlayerMoved === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: got PlayerMoved=1, expected 0 (P1=%h P2=%h)",
                 intf.P1, intf.P2);
      end else begin
        e = exp_q.pop_front();
        check("pulse_P1",      64'(intf.P1),      64'(e.p1));
        check("pulse_P2",      64'(intf.P2),      64'(e.p2));
        check("pulse_I",       64'(intf.I),       64'(e.cur));
        check("pulse_P1Won",   64'(intf.P1Won),   64'(e.w1));
        check("pulse_P2Won",   64'(intf.P2Won),   64'(e.w2));
        check("pulse_convert", 64'(intf.convert), 64'(e.conv));
      end
    end
  end

  // Called at a falling edge; drives buttons for 'hold' cycles then releases
  task automatic press(input logic [4:0] m, input int hold, input string tag);
    model_apply(m);
    {intf.BtnC, intf.BtnU, intf.BtnD, intf.BtnL, intf.BtnR} = m;
    repeat (hold) @(negedge Clk);
    {intf.BtnC, intf.BtnU, intf.BtnD, intf.BtnL, intf.BtnR} = 5'd0;
    @(negedge Clk);
    check_state(tag);
  endtask

  task automatic do_restart(input logic [4:0] m);
    model_reset();
    intf.restart = 1'b1;
    {intf.BtnC, intf.BtnU, intf.BtnD, intf.BtnL, intf.BtnR} = m;
    @(negedge Clk);
    intf.restart = 1'b0;
    {intf.BtnC, intf.BtnU, intf.BtnD, intf.BtnL, intf.BtnR} = 5'd0;
    @(negedge Clk);
    check_state("restart");
  endtask

  task automatic goto_cell(input int target);
    while (m_cursor / 3 > target / 3) press(5'b01000, 1, "up");
    while (m_cursor / 3 < target / 3) press(5'b00100, 1, "down");
    while (m_cursor % 3 > target % 3) press(5'b00010, 1, "left");
    while (m_cursor % 3 < target % 3) press(5'b00001, 1, "right");
  endtask

  task automatic place_at(input int target);
    goto_cell(target);
    press(5'b10000, 1, "place");
  endtask

  int draw_seq[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

  initial begin
    #2_000_000;
    fails++;
    $display("FAIL watchdog: got no finish, expected finish within time budget");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    logic [4:0] m;
    int r;
    reset        = 1'b1;
    intf.restart = 1'b0;
    {intf.BtnC, intf.BtnU, intf.BtnD, intf.BtnL, intf.BtnR} = 5'd0;
    model_reset();
    repeat (2) @(negedge Clk);
    reset = 1'b0;
    @(negedge Clk);
    check_state("reset");

    // Cursor navigation and edge clamping
    press(5'b01000, 1, "U_4to1");
    press(5'b00010, 1, "L_1to0");
    press(5'b01000, 1, "U_clamp0");
    press(5'b00001, 1, "R_0to1");
    press(5'b00001, 1, "R_1to2");
    press(5'b00001, 1, "R_clamp2");
    press(5'b00100, 1, "D_2to5");
    press(5'b00100, 1, "D_5to8");
    press(5'b00100, 1, "D_clamp8");
    press(5'b00001, 1, "R_clamp8");

    // Placement, rejection on occupied cell, second player
    do_restart(5'b00001);
    press(5'b10000, 1, "C_at4");
    press(5'b10000, 1, "C_occupied");
    goto_cell(0);
    press(5'b10000, 1, "C_P2_at0");

    // P1 wins with the top row; later presses are ignored
    do_restart(5'd0);
    place_at(0); place_at(3); place_at(1); place_at(4); place_at(2);
    goto_cell(5);
    press(5'b10000, 1, "C_after_win");
    do_restart(5'd0);

    // Long hold gives one placement; C beats R on the same edge
    press(5'b10000, 5, "C_hold5");
    goto_cell(0);
    press(5'b10001, 1, "C_and_R");

    // Draw: full board with no line, further C rejected
    do_restart(5'd0);
    for (int k = 0; k < 9; k++) place_at(draw_seq[k]);
    press(5'b10000, 1, "C_after_draw");

    // Asynchronous reset in the middle of a game
    do_restart(5'd0);
    place_at(2); place_at(6);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check_state("async_reset");
    @(negedge Clk);
    reset = 1'b0;
    @(negedge Clk);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        do_restart(5'($urandom_range(0, 31)));
      end else if (r < 15) begin
        m = 5'($urandom_range(1, 31));
        press(m, $urandom_range(1, 3), "rand_multi");
      end else if (r < 45) begin
        press(5'b10000, $urandom_range(1, 3), "rand_C");
      end else begin
        m = 5'd1 << $urandom_range(0, 3);
        press(m, $urandom_range(1, 3), "rand_move");
      end
    end

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
